// File: rtl/id_ex_register_pkg.sv
// Shared decode constants for the ID, ID/EX latch and ALU control stages.
// Holds op-class encodings, operand-select codes and default bus widths.
package id_ex_register_pkg;

  localparam int DEF_BUS_SIZE            = 32;
  localparam int DEF_REG_ADDR_WIDTH      = 5;
  localparam int DEF_ALU_OP_BUS_WIDTH    = 3;
  localparam int DEF_ALU_FUNCT_BUS_WIDTH = 6;

  // UNDEFINED is deliberately not R_TYPE so a bubble decodes as NOP
  localparam logic [2:0] CODE_ALU_CTR_LOAD_STORE = 3'b000;
  localparam logic [2:0] CODE_ALU_CTR_R_TYPE     = 3'b001;
  localparam logic [2:0] CODE_ALU_CTR_ADDI       = 3'b010;
  localparam logic [2:0] CODE_ALU_CTR_ANDI       = 3'b011;
  localparam logic [2:0] CODE_ALU_CTR_ORI        = 3'b100;
  localparam logic [2:0] CODE_ALU_CTR_XORI       = 3'b101;
  localparam logic [2:0] CODE_ALU_CTR_SLTI       = 3'b110;
  localparam logic [2:0] CODE_ALU_CTR_UNDEFINED  = 3'b111;

  localparam logic [1:0] ALU_SRC_B_DATA   = 2'd0;
  localparam logic [1:0] ALU_SRC_B_EXT    = 2'd1;
  localparam logic [1:0] ALU_SRC_B_CONST4 = 2'd2;

  localparam logic [1:0] REG_DST_RT  = 2'd0;
  localparam logic [1:0] REG_DST_RD  = 2'd1;
  localparam logic [1:0] REG_DST_R31 = 2'd2;

  localparam logic [1:0] MEM_MASK_BYTE = 2'd0;
  localparam logic [1:0] MEM_MASK_HALF = 2'd1;
  localparam logic [1:0] MEM_MASK_WORD = 2'd2;

endpackage

// File: rtl/id_ex_register.sv
// ID/EX pipeline latch with freeze, bubble insertion and a valid tag.
// Priority per edge: reset > freeze (enable low) > flush > load.
module id_ex_register
  import id_ex_register_pkg::*;
#(
  parameter int BUS_SIZE            = DEF_BUS_SIZE,
  parameter int REG_ADDR_WIDTH      = DEF_REG_ADDR_WIDTH,
  parameter int ALU_OP_BUS_WIDTH    = DEF_ALU_OP_BUS_WIDTH,
  parameter int ALU_FUNCT_BUS_WIDTH = DEF_ALU_FUNCT_BUS_WIDTH
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_enable,
  input  logic                           i_flush,
  input  logic [BUS_SIZE-1:0]            i_pc_next,
  input  logic [BUS_SIZE-1:0]            i_data_a,
  input  logic [BUS_SIZE-1:0]            i_data_b,
  input  logic [BUS_SIZE-1:0]            i_extension,
  input  logic [REG_ADDR_WIDTH-1:0]      i_shamt,
  input  logic [REG_ADDR_WIDTH-1:0]      i_rs,
  input  logic [REG_ADDR_WIDTH-1:0]      i_rt,
  input  logic [REG_ADDR_WIDTH-1:0]      i_rd,
  input  logic [ALU_FUNCT_BUS_WIDTH-1:0] i_funct,
  input  logic [ALU_OP_BUS_WIDTH-1:0]    i_alu_op,
  input  logic                           i_alu_src_a,
  input  logic [1:0]                     i_alu_src_b,
  input  logic [1:0]                     i_reg_dst,
  input  logic                           i_mem_rd,
  input  logic                           i_mem_wr,
  input  logic                           i_wb,
  input  logic                           i_mem_to_reg,
  input  logic [1:0]                     i_mem_mask,
  input  logic                           i_unsigned,
  input  logic                           i_halt,
  output logic [BUS_SIZE-1:0]            o_pc_next,
  output logic [BUS_SIZE-1:0]            o_data_a,
  output logic [BUS_SIZE-1:0]            o_data_b,
  output logic [BUS_SIZE-1:0]            o_extension,
  output logic [REG_ADDR_WIDTH-1:0]      o_shamt,
  output logic [REG_ADDR_WIDTH-1:0]      o_rs,
  output logic [REG_ADDR_WIDTH-1:0]      o_rt,
  output logic [REG_ADDR_WIDTH-1:0]      o_rd,
  output logic [ALU_FUNCT_BUS_WIDTH-1:0] o_funct,
  output logic [ALU_OP_BUS_WIDTH-1:0]    o_alu_op,
  output logic                           o_alu_src_a,
  output logic [1:0]                     o_alu_src_b,
  output logic [1:0]                     o_reg_dst,
  output logic                           o_mem_rd,
  output logic                           o_mem_wr,
  output logic                           o_wb,
  output logic                           o_mem_to_reg,
  output logic [1:0]                     o_mem_mask,
  output logic                           o_unsigned,
  output logic                           o_halt,
  output logic                           o_valid
);

  // Bubble bundle: every field zero except the op class, which must not decode as R-type
  localparam logic [BUS_SIZE-1:0]            BUBBLE_DATA   = '0;
  localparam logic [REG_ADDR_WIDTH-1:0]      BUBBLE_ADDR   = '0;
  localparam logic [ALU_FUNCT_BUS_WIDTH-1:0] BUBBLE_FUNCT  = '0;
  localparam logic [ALU_OP_BUS_WIDTH-1:0]    BUBBLE_ALU_OP = ALU_OP_BUS_WIDTH'(CODE_ALU_CTR_UNDEFINED);
  localparam logic [1:0]                     BUBBLE_SEL    = 2'd0;

  logic w_load_bubble;
  assign w_load_bubble = i_reset || (i_enable && i_flush);

  always_ff @(posedge i_clk) begin
    if (w_load_bubble) begin
      o_pc_next    <= BUBBLE_DATA;
      o_data_a     <= BUBBLE_DATA;
      o_data_b     <= BUBBLE_DATA;
      o_extension  <= BUBBLE_DATA;
      o_shamt      <= BUBBLE_ADDR;
      o_rs         <= BUBBLE_ADDR;
      o_rt         <= BUBBLE_ADDR;
      o_rd         <= BUBBLE_ADDR;
      o_funct      <= BUBBLE_FUNCT;
      o_alu_op     <= BUBBLE_ALU_OP;
      o_alu_src_a  <= 1'b0;
      o_alu_src_b  <= BUBBLE_SEL;
      o_reg_dst    <= BUBBLE_SEL;
      o_mem_rd     <= 1'b0;
      o_mem_wr     <= 1'b0;
      o_wb         <= 1'b0;
      o_mem_to_reg <= 1'b0;
      o_mem_mask   <= BUBBLE_SEL;
      o_unsigned   <= 1'b0;
      o_halt       <= 1'b0;
      o_valid      <= 1'b0;
    end else if (i_enable) begin
      o_pc_next    <= i_pc_next;
      o_data_a     <= i_data_a;
      o_data_b     <= i_data_b;
      o_extension  <= i_extension;
      o_shamt      <= i_shamt;
      o_rs         <= i_rs;
      o_rt         <= i_rt;
      o_rd         <= i_rd;
      o_funct      <= i_funct;
      o_alu_op     <= i_alu_op;
      o_alu_src_a  <= i_alu_src_a;
      o_alu_src_b  <= i_alu_src_b;
      o_reg_dst    <= i_reg_dst;
      o_mem_rd     <= i_mem_rd;
      o_mem_wr     <= i_mem_wr;
      o_wb         <= i_wb;
      o_mem_to_reg <= i_mem_to_reg;
      o_mem_mask   <= i_mem_mask;
      o_unsigned   <= i_unsigned;
      o_halt       <= i_halt;
      o_valid      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_register.sv
// Self-checking bench for id_ex_register: directed test-plan steps followed by
// random reset/freeze/flush/load traffic against a whole-record reference model.
module tb_id_ex_register;
  import id_ex_register_pkg::*;

  typedef struct packed {
    logic [31:0] pcNext;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [31:0] extension;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [2:0]  aluOp;
    logic        aluSrcA;
    logic [1:0]  aluSrcB;
    logic [1:0]  regDst;
    logic        memRd;
    logic        memWr;
    logic        wb;
    logic        memToReg;
    logic [1:0]  memMask;
    logic        isUnsigned;
    logic        halt;
  } fields_t;

  logic    clock = 1'b0;
  logic    reset, enable, flush;
  fields_t stim;
  fields_t obs;
  logic    oValid;

  logic [31:0] oPcNext, oDataA, oDataB, oExtension;
  logic [4:0]  oShamt, oRs, oRt, oRd;
  logic [5:0]  oFunct;
  logic [2:0]  oAluOp;
  logic        oAluSrcA, oMemRd, oMemWr, oWb, oMemToReg, oUnsigned, oHalt;
  logic [1:0]  oAluSrcB, oRegDst, oMemMask;

  fields_t expFields;
  logic    expValid;
  int      compared   = 0;
  int      mismatched = 0;

  always #5 clock = ~clock;

  id_ex_register dut (
    .i_clk(clock), .i_reset(reset), .i_enable(enable), .i_flush(flush),
    .i_pc_next(stim.pcNext), .i_data_a(stim.dataA), .i_data_b(stim.dataB),
    .i_extension(stim.extension), .i_shamt(stim.shamt), .i_rs(stim.rs),
    .i_rt(stim.rt), .i_rd(stim.rd), .i_funct(stim.funct), .i_alu_op(stim.aluOp),
    .i_alu_src_a(stim.aluSrcA), .i_alu_src_b(stim.aluSrcB), .i_reg_dst(stim.regDst),
    .i_mem_rd(stim.memRd), .i_mem_wr(stim.memWr), .i_wb(stim.wb),
    .i_mem_to_reg(stim.memToReg), .i_mem_mask(stim.memMask),
    .i_unsigned(stim.isUnsigned), .i_halt(stim.halt),
    .o_pc_next(oPcNext), .o_data_a(oDataA), .o_data_b(oDataB),
    .o_extension(oExtension), .o_shamt(oShamt), .o_rs(oRs), .o_rt(oRt), .o_rd(oRd),
    .o_funct(oFunct), .o_alu_op(oAluOp), .o_alu_src_a(oAluSrcA),
    .o_alu_src_b(oAluSrcB), .o_reg_dst(oRegDst), .o_mem_rd(oMemRd),
    .o_mem_wr(oMemWr), .o_wb(oWb), .o_mem_to_reg(oMemToReg),
    .o_mem_mask(oMemMask), .o_unsigned(oUnsigned), .o_halt(oHalt),
    .o_valid(oValid)
  );

  assign obs = {oPcNext, oDataA, oDataB, oExtension, oShamt, oRs, oRt, oRd, oFunct,
                oAluOp, oAluSrcA, oAluSrcB, oRegDst, oMemRd, oMemWr, oWb, oMemToReg,
                oMemMask, oUnsigned, oHalt};

  function automatic fields_t bubbleFields();
    fields_t b = '0;
    b.aluOp = CODE_ALU_CTR_UNDEFINED;
    return b;
  endfunction

  function automatic fields_t randomFields();
    fields_t f;
    f.pcNext     = $urandom;
    f.dataA      = $urandom;
    f.dataB      = $urandom;
    f.extension  = $urandom;
    f.shamt      = 5'($urandom);
    f.rs         = 5'($urandom);
    f.rt         = 5'($urandom);
    f.rd         = 5'($urandom);
    f.funct      = 6'($urandom);
    f.aluOp      = 3'($urandom_range(0, 7));
    f.aluSrcA    = 1'($urandom);
    f.aluSrcB    = 2'($urandom_range(0, 2));
    f.regDst     = 2'($urandom_range(0, 2));
    f.memRd      = 1'($urandom);
    f.memWr      = 1'($urandom);
    f.wb         = 1'($urandom);
    f.memToReg   = 1'($urandom);
    f.memMask    = 2'($urandom_range(0, 2));
    f.isUnsigned = 1'($urandom);
    f.halt       = 1'($urandom);
    return f;
  endfunction

  // Drive one edge's worth of inputs at a falling edge, advance the model at the
  // rising edge, and leave the bench at the next falling edge for sampling.
  task automatic applyStimulus(input logic r, input logic en, input logic fl, input fields_t f);
    reset  = r;
    enable = en;
    flush  = fl;
    stim   = f;
    @(posedge clock);
    if (r || (en && fl)) begin
      expFields = bubbleFields();
      expValid  = 1'b0;
    end else if (en) begin
      expFields = f;
      expValid  = 1'b1;
    end
    @(negedge clock);
  endtask

  task automatic checkOutput(input string tag);
    compared++;
    assert (obs === expFields && oValid === expValid)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%h valid=%b expected=%h valid=%b",
             tag, obs, oValid, expFields, expValid);
    end
  endtask

  task automatic checkField(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    fields_t f;
    int r, en, fl;
    reset = 1'b0; enable = 1'b0; flush = 1'b0; stim = '0;
    expFields = bubbleFields(); expValid = 1'b0;
    @(negedge clock);

    applyStimulus(1'b1, 1'b1, 1'b0, randomFields());
    checkOutput("reset");
    checkField("reset_alu_op", 32'(oAluOp), 32'(CODE_ALU_CTR_UNDEFINED));
    checkField("reset_valid", 32'(oValid), 32'd0);

    f = randomFields();
    f.dataA = 32'h0000_00AA; f.rd = 5'd9; f.funct = 6'h21;
    f.aluOp = CODE_ALU_CTR_R_TYPE; f.wb = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, f);
    checkOutput("load");
    checkField("load_data_a", oDataA, 32'h0000_00AA);
    checkField("load_rd", 32'(oRd), 32'd9);
    checkField("load_funct", 32'(oFunct), 32'h21);
    checkField("load_valid", 32'(oValid), 32'd1);

    f = randomFields();
    f.dataB = 32'h1234_5678;
    applyStimulus(1'b0, 1'b1, 1'b0, f);
    checkOutput("freeze_preload");
    for (int i = 0; i < 3; i++) begin
      f = randomFields();
      f.dataB = 32'hFFFF_FFFF;
      applyStimulus(1'b0, 1'b0, 1'b1, f);
      checkField("freeze_data_b", oDataB, 32'h1234_5678);
      checkField("freeze_valid", 32'(oValid), 32'd1);
      checkOutput("freeze_hold");
    end

    f = randomFields();
    applyStimulus(1'b0, 1'b1, 1'b0, f);
    checkOutput("freeze_release_load");

    f = randomFields();
    f.memWr = 1'b1; f.halt = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1, f);
    checkField("flush_mem_wr", 32'(oMemWr), 32'd0);
    checkField("flush_halt", 32'(oHalt), 32'd0);
    checkField("flush_valid", 32'(oValid), 32'd0);
    checkOutput("flush");
    f = randomFields();
    applyStimulus(1'b0, 1'b1, 1'b0, f);
    checkOutput("after_flush_load");

    applyStimulus(1'b0, 1'b1, 1'b1, randomFields());
    checkOutput("flush_run_1");
    applyStimulus(1'b0, 1'b1, 1'b1, randomFields());
    checkOutput("flush_run_2");

    applyStimulus(1'b0, 1'b1, 1'b0, randomFields());
    applyStimulus(1'b1, 1'b0, 1'b0, randomFields());
    checkOutput("reset_over_freeze");
    checkField("reset_over_freeze_valid", 32'(oValid), 32'd0);

    f = randomFields();
    f.halt = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, f);
    checkField("halt_propagate", 32'(oHalt), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, randomFields());
    checkField("halt_flushed", 32'(oHalt), 32'd0);

    for (int i = 0; i < 300; i++) begin
      r  = ($urandom_range(0, 19) == 0) ? 1 : 0;
      en = ($urandom_range(0, 3) != 0) ? 1 : 0;
      fl = ($urandom_range(0, 4) == 0) ? 1 : 0;
      applyStimulus(1'(r), 1'(en), 1'(fl), randomFields());
      checkOutput("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/id_ex_register.md
# id_ex_register

Pipeline latch between instruction decode and execute. It captures the decoded operands, register addresses, ALU selector fields and downstream control bits on each enabled clock edge, and presents them to the execute stage (ALU control, ALU, operand muxes) for one cycle. It supports pipeline freeze (debug step/halt), bubble insertion (hazard flush), and a valid/halt tag that travels with each instruction.

## Interface
- BUS_SIZE, 32, data/PC width
- REG_ADDR_WIDTH, 5, register-file address width
- ALU_OP_BUS_WIDTH, 3, width of decoded ALU op class
- ALU_FUNCT_BUS_WIDTH, 6, width of R-type funct field

Clock and reset: one clock; reset is synchronous and active-high.
- i_clk  in  1  clock; all state updates on rising edge
- i_reset  in  1  synchronous, active-high; loads the bubble state
- i_enable  in  1  pipeline advance; 0 freezes all state
- i_flush  in  1  load bubble instead of ID inputs
- i_pc_next  in  BUS_SIZE  PC+4 of the decoded instruction
- i_data_a, i_data_b  in  BUS_SIZE each  register-file read data
- i_extension  in  BUS_SIZE  sign/zero-extended immediate
- i_shamt  in  REG_ADDR_WIDTH  shift amount
- i_rs, i_rt, i_rd  in  REG_ADDR_WIDTH each  register addresses
- i_funct  in  ALU_FUNCT_BUS_WIDTH  funct field
- i_alu_op  in  ALU_OP_BUS_WIDTH  op class for ALU control
- i_alu_src_a  in  1  0: data_a, 1: shamt
- i_alu_src_b  in  2  0: data_b, 1: extension, 2: const 4 (link)
- i_reg_dst  in  2  0: rt, 1: rd, 2: r31
- i_mem_rd, i_mem_wr, i_wb, i_mem_to_reg  in  1 each  downstream control
- i_mem_mask  in  2  byte/half/word
- i_unsigned  in  1  zero-extend loads
- i_halt  in  1  decoded HALT
- o_*  out  same widths  registered copy of every i_* data/control field above
- o_valid  out  1  1: real instruction, 0: bubble

## Operation
- Three mutually exclusive update modes per rising edge, priority reset > freeze > flush > load.
- Reset (i_reset=1): load bubble, regardless of i_enable.
- Freeze (i_enable=0): every output holds; i_flush ignored.
- Flush (i_enable=1, i_flush=1): load bubble.
- Load (i_enable=1, i_flush=0): every o_* takes its i_* value; o_valid=1.
- Bubble state: all data/address fields 0; o_mem_rd=o_mem_wr=o_wb=o_mem_to_reg=o_halt=0; o_alu_src_a=0, o_alu_src_b=0, o_reg_dst=0, o_mem_mask=0, o_unsigned=0; o_alu_op=CODE_ALU_CTR_UNDEFINED (not R-type, so ALU control decodes NOP even with funct=0); o_valid=0.
- A bubble has no architectural effect: no memory access, no write-back, no halt.
- o_halt propagates like any control bit; this block does not stop the pipeline itself.
- No arithmetic; fields are passed through bit-exact, without widening or truncation.

## Timing
- Latency: 1 cycle from ID inputs to o_* on a load edge.
- All outputs come straight from flops; there is no combinational input→output path.
- Reset values: all outputs equal the bubble state, including o_valid=0.
- Flush and reset take effect at the same edge they are sampled; the next cycle shows the bubble.
- Reset asserted mid-freeze: bubble loads at that edge; the frozen contents are lost.
- Flush held for N enabled cycles: N consecutive bubbles.
- Freeze then release: the first enabled edge loads the inputs present at that edge; inputs seen during the freeze are not captured.

## Structure
- Shared package/header: CODE_ALU_CTR_* op-class encodings (including CODE_ALU_CTR_UNDEFINED), ALU_SRC_B_*, REG_DST_*, MEM_MASK_* constants, and default width macros. ALU control and the decoder use the same header.
- Single module. The bubble value is a localparam bundle applied in one always block.
- No sub-module.

## Test plan
- Reset: i_reset=1 with random inputs, i_enable=1 → all o_* zero, o_alu_op=CODE_ALU_CTR_UNDEFINED, o_valid=0.
- Load: i_enable=1, i_data_a=0x0000_00AA, i_rd=5'd9, i_funct=6'h21, i_alu_op=R-type, i_wb=1 → next cycle same values, o_valid=1.
- Freeze: load i_data_b=0x1234_5678, then i_enable=0 for 3 cycles with i_data_b=0xFFFF_FFFF and i_flush=1 → o_data_b stays 0x1234_5678 and o_valid stays 1 throughout.
- Flush: i_enable=1, i_flush=1, i_mem_wr=1, i_halt=1 → o_mem_wr=0, o_halt=0, o_valid=0; with i_flush=0 on the next edge, the inputs load normally.
- Priority: i_reset=1, i_enable=0, valid contents held → bubble loaded at that edge.
- Halt propagation: load i_halt=1 → o_halt=1 one cycle later; then i_flush=1 → o_halt=0.
